// File: rtl/debouncer_pkg.sv
// Shared constants for the pushbutton debouncer.
package debouncer_pkg;

  // Stability window giving 20 us of required quiet time at a 50 MHz clock.
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1000;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Generic 1-bit two-stage synchronizer with synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync0;

  // Two flops in series; only sync0 may go metastable, q is the settled sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync0 <= d;
      q     <= sync0;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Pushbutton debouncer: synchronizes the raw pin, qualifies changes over a
// stability window, and publishes a clean level plus press/release strobes.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_state,
  output logic press_pulse,
  output logic release_pulse
);

  logic             sync1;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button),
    .q   (sync1)
  );

  // Count consecutive disagreeing cycles; accept the new level when the window
  // completes and strobe on the same edge. Any agreement restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      button_state  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync1 == button_state) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        cnt           <= '0;
        button_state  <= sync1;
        press_pulse   <= sync1;
        release_pulse <= ~sync1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_debouncer.sv
`timescale 1ns/1ps
module tb_debouncer;

  localparam int unsigned N = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b1;
  logic button_state, press_pulse, release_pulse;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    logic        rise;
  } ev_t;

  ev_t exp_q[$];

  debouncer #(.STABLE_CYCLES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .button_state  (button_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #10 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called right after a level change is driven at a negedge: the next edge
  // samples it, so the output moves N+2 edges after the current count.
  task automatic expect_edge(input logic rise);
    ev_t e;
    e.cyc  = cyc + N + 2;
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (press_pulse || release_pulse) begin
      ev_t e;
      check_eq("strobe_exclusive", 32'(press_pulse & release_pulse), 0);
      check_eq("strobe_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("strobe_cycle", cyc, e.cyc);
        check_eq("strobe_kind", 32'(press_pulse), 32'(e.rise));
        check_eq("state_at_strobe", 32'(button_state), 32'(e.rise));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t;

    // 1: reset with button held high, then press after full latency.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("reset_state", 32'(button_state), 0);
      check_eq("reset_press", 32'(press_pulse), 0);
      check_eq("reset_release", 32'(release_pulse), 0);
    end
    rst = 1'b0;
    expect_edge(1'b1);
    tick(N + 1);
    check_eq("reset_latency_early", 32'(button_state), 0);
    tick(1);
    check_eq("reset_latency_on", 32'(button_state), 1);

    button = 1'b0;
    expect_edge(1'b0);
    tick(N + 10);
    check_eq("release_after_reset", 32'(button_state), 0);

    // 2: bounce train with sub-cycle segments and a 50-cycle plateau.
    for (int r = 0; r < 6; r++) begin
      for (int s = 1; s <= 4; s++) begin
        button = ~button;
        #(10 * s);
      end
    end
    @(negedge clk);
    button = 1'b1;
    tick(50);
    for (int r = 0; r < 6; r++) begin
      for (int s = 4; s >= 1; s--) begin
        button = ~button;
        #(10 * s);
      end
    end
    @(negedge clk);
    button = 1'b0;
    tick(N + 10);
    check_eq("bounce_state", 32'(button_state), 0);

    // 3: clean 100 us press.
    button = 1'b1;
    expect_edge(1'b1);
    tick(5000);
    check_eq("clean_press_state", 32'(button_state), 1);
    check_eq("clean_press_idle", 32'(press_pulse), 0);

    // 4: release with a one-cycle glitch at 500 cycles.
    button = 1'b0;
    tick(500);
    button = 1'b1;
    tick(1);
    button = 1'b0;
    expect_edge(1'b0);
    tick(N / 2 + 100);
    check_eq("glitch_hold_state", 32'(button_state), 1);
    tick(N);
    check_eq("glitch_release_state", 32'(button_state), 0);

    // 5: boundary pulses: 999 cycles rejected, 1000 cycles accepted.
    button = 1'b1;
    tick(N - 1);
    button = 1'b0;
    tick(N + 10);
    check_eq("pulse999_rejected", 32'(button_state), 0);
    button = 1'b1;
    expect_edge(1'b1);
    tick(N);
    button = 1'b0;
    expect_edge(1'b0);
    tick(N + 10);
    check_eq("pulse1000_done", 32'(button_state), 0);

    // 6: reset mid-window restarts qualification from zero.
    button = 1'b1;
    tick(800);
    rst = 1'b1;
    tick(1);
    check_eq("midreset_cnt", 32'(dut.cnt), 0);
    check_eq("midreset_state", 32'(button_state), 0);
    rst = 1'b0;
    expect_edge(1'b1);
    t = cyc + N + 2;
    tick(N + 1);
    check_eq("midreset_not_early", 32'(button_state), 0);
    tick(1);
    check_eq("midreset_cycle", cyc, t);
    check_eq("midreset_state_on", 32'(button_state), 1);

    tick(5);
    check_eq("leftover_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
